ml_ahb_master_port_stage: RTL and testbench
===========================================

Name: ml_ahb_master_port_stage

Overview:
- Master-side input stage of the multi-layer AHB interconnect; one instance per AHB master layer.
- It sits opposite the per-slave-port arbiters: it decodes the master's address and raises a per-slave-port request toward the arbiters.
- When an arbiter does not grant, the stage holds and replays the address phase, stalling the master with hready_out low.
- It routes the data-phase response and read data from the selected slave port back to the master. Unmapped addresses go to an internal default slave that returns ERROR.

Parameters:
NB_SLAVE_PORT, 2, number of slave ports reachable from this master.
SLV_BASE, {32'h1000_0000,32'h0000_0000}, concatenated 32-bit base address per slave port; port 0 in the LSBs.
SLV_MASK, {32'hF000_0000,32'hF000_0000}, concatenated 32-bit decode mask per slave port.

Ports:
hclk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
haddr  in  32  master address
htrans  in  2  master transfer type
hwrite  in  1  master write
hsize  in  3  master size
hburst  in  3  master burst
hready_out  out  1  ready to master
hresp_out  out  1  response to master (1 = ERROR)
hrdata_out  out  32  read data to master
sx_sel  out  NB_SLAVE_PORT  one-hot request to each slave-port arbiter
s_haddr  out  32  address to slave ports (live or held)
s_htrans  out  2  transfer type to slave ports
s_hwrite  out  1  write to slave ports
s_hsize  out  3  size to slave ports
s_hburst  out  3  burst to slave ports
sx_grant  in  NB_SLAVE_PORT  grant from each slave-port arbiter for this master
sx_hready  in  NB_SLAVE_PORT  hready of each slave port
sx_hresp  in  NB_SLAVE_PORT  hresp of each slave port
sx_hrdata  in  NB_SLAVE_PORT*32  read data of each slave port

Behaviour:
- Decode:
  - Slave i matches when (a & SLV_MASK[i]) == SLV_BASE[i]; on overlap the lowest index wins.
  - No match gives miss = 1.
  - The decode uses the held address in HOLD, otherwise the live haddr.
- Valid transfer: htrans is NONSEQ (2'b10) or SEQ (2'b11). IDLE and BUSY never assert sx_sel and get zero-wait OKAY.
- sx_sel = one-hot(decoded index) when the transfer is valid and miss = 0; otherwise all zero.
- s_* outputs: held registers in HOLD, otherwise the live master signals.
- Slave acceptance of an address phase for slave s = sx_sel[s] & sx_grant[s] & sx_hready[s], sampled at the clock edge.
- States:
  - ADDR (reset state):
    - Capture happens only when hready_out = 1.
    - Valid transfer with miss = 1 -> ERR1.
    - Valid transfer, no miss, accepted -> stay in ADDR; dvalid = 1; dsel = s.
    - Valid transfer, no miss, not accepted -> capture haddr/htrans/hwrite/hsize/hburst into the hold registers; go to HOLD; dvalid = 0.
    - IDLE/BUSY -> dvalid = 0.
  - HOLD:
    - hready_out = 0.
    - On acceptance -> ADDR, dvalid = 1, dsel = held index.
    - Otherwise stay; requests persist every cycle.
  - ERR1: hready_out = 0, hresp_out = 1 -> ERR2.
  - ERR2: hready_out = 1, hresp_out = 1 -> ADDR.
    - The master address presented in ERR2 is decoded and handled as in ADDR. Capture is allowed because hready_out = 1.
- Response mux:
  - In ADDR with dvalid = 1: hready_out = sx_hready[dsel], hresp_out = sx_hresp[dsel], hrdata_out = sx_hrdata[dsel].
  - In ADDR with dvalid = 0: hready_out = 1, hresp_out = 0, hrdata_out = 0.
- Data phase with hready_out = 0: no capture and no state change. sx_sel still follows the live address, because the arbiters gate on hready.
- Slave ERROR responses pass through unchanged; the stage does not cancel held or following transfers.
- Reset values:
  - state = ADDR; dvalid = 0; dsel = 0; hold registers = 0.
  - hready_out = 1, hresp_out = 0, hrdata_out = 0, sx_sel = 0.
  - s_htrans = 2'b00, since the master drives IDLE while in reset.
- Reset asserted mid-HOLD or mid-ERR: the pending transfer is dropped and every output returns to its reset value.
- Latency: zero added cycles when granted. Each cycle spent in HOLD adds one wait state.

Decomposition:
- Shared package ml_ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants.
  - The stage state encoding: ADDR = 2'd0, HOLD = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3.
- Sub-module ml_ahb_addr_decod: purely combinational; address -> one-hot select + miss, parameterised by SLV_BASE/SLV_MASK.

Test Plan:
- Granted access: NONSEQ read to 0x1000_0004 with sx_grant = 2'b10 and sx_hready = 2'b11 -> sx_sel = 2'b10; next cycle hready_out = 1 and hrdata_out = sx_hrdata[63:32]; state never leaves ADDR.
- Held access: NONSEQ to 0x0000_0010 with sx_grant = 0 for 3 cycles, then 1 -> hready_out = 0 for 3 cycles; s_haddr stays 0x0000_0010 while the master drives 0x0000_0014; data phase then completes from slave 0.
- Unmapped address: NONSEQ to 0x2000_0000 -> sx_sel = 0; hready_out/hresp_out sequence is 0/1 then 1/1, then 1/0.
- Slave wait states: dsel = 1 with sx_hready[1] low for 2 cycles -> hready_out low for 2 cycles and the next address is not captured; 4-beat INCR burst with SEQ beats is accepted back-to-back.
- Reset during HOLD: resetn pulsed low -> sx_sel = 0, s_htrans = 0, hready_out = 1 asynchronously; after release the next NONSEQ is decoded fresh.
- IDLE/BUSY: htrans = 2'b01 to a mapped address -> sx_sel = 0; next cycle hready_out = 1 and hresp_out = 0.

Source files
------------

// File: rtl/ml_ahb_pkg.sv
// Shared AHB constants and the master-port stage state encoding.
package ml_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } stage_state_e;

endpackage

// File: rtl/ml_ahb_addr_decod.sv
// Address decoder: one-hot slave-port select plus miss; lowest index wins on overlap.
module ml_ahb_addr_decod #(
  parameter int                          NB_SLAVE_PORT = 2,
  parameter logic [NB_SLAVE_PORT*32-1:0] SLV_BASE      = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE_PORT*32-1:0] SLV_MASK      = {32'hF000_0000, 32'hF000_0000},
  localparam int                         IW            = (NB_SLAVE_PORT > 1) ? $clog2(NB_SLAVE_PORT) : 1
) (
  input  logic [31:0]              addr,
  output logic [NB_SLAVE_PORT-1:0] sel,
  output logic [IW-1:0]            idx,
  output logic                     miss
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    sel  = '0;
    idx  = '0;
    miss = 1'b1;
    for (int i = NB_SLAVE_PORT - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = IW'(i);
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ml_ahb_master_port_stage.sv
// Master-side input stage of the multi-layer AHB matrix: decode, request, hold/replay
// on lost arbitration, default-slave ERROR, and data-phase response mux.
module ml_ahb_master_port_stage
  import ml_ahb_pkg::*;
#(
  parameter int                          NB_SLAVE_PORT = 2,
  parameter logic [NB_SLAVE_PORT*32-1:0] SLV_BASE      = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE_PORT*32-1:0] SLV_MASK      = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                        hclk,
  input  logic                        resetn,
  input  logic [31:0]                 haddr,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [2:0]                  hsize,
  input  logic [2:0]                  hburst,
  output logic                        hready_out,
  output logic                        hresp_out,
  output logic [31:0]                 hrdata_out,
  output logic [NB_SLAVE_PORT-1:0]    sx_sel,
  output logic [31:0]                 s_haddr,
  output logic [1:0]                  s_htrans,
  output logic                        s_hwrite,
  output logic [2:0]                  s_hsize,
  output logic [2:0]                  s_hburst,
  input  logic [NB_SLAVE_PORT-1:0]    sx_grant,
  input  logic [NB_SLAVE_PORT-1:0]    sx_hready,
  input  logic [NB_SLAVE_PORT-1:0]    sx_hresp,
  input  logic [NB_SLAVE_PORT*32-1:0] sx_hrdata
);

  localparam int IW = (NB_SLAVE_PORT > 1) ? $clog2(NB_SLAVE_PORT) : 1;

  stage_state_e state, state_nxt;
  logic           dvalid, dvalid_nxt;
  logic [IW-1:0]  dsel, dsel_nxt;
  logic           capture;

  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic [2:0]  hold_burst;

  logic                     in_hold;
  logic                     xfer_vld;
  logic                     accept;
  logic [NB_SLAVE_PORT-1:0] dec_sel;
  logic [IW-1:0]            dec_idx;
  logic                     dec_miss;

  assign in_hold  = (state == ST_HOLD);
  assign s_haddr  = in_hold ? hold_addr  : haddr;
  assign s_hwrite = in_hold ? hold_write : hwrite;
  assign s_hsize  = in_hold ? hold_size  : hsize;
  assign s_hburst = in_hold ? hold_burst : hburst;
  // Force IDLE while in reset so no arbiter sees a request, whatever the master drives.
  assign s_htrans = !resetn ? HTRANS_IDLE : (in_hold ? hold_trans : htrans);
  assign xfer_vld = s_htrans[1];

  ml_ahb_addr_decod #(
    .NB_SLAVE_PORT (NB_SLAVE_PORT),
    .SLV_BASE      (SLV_BASE),
    .SLV_MASK      (SLV_MASK)
  ) u_decod (
    .addr (s_haddr),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign sx_sel = (xfer_vld && !dec_miss) ? dec_sel : '0;
  assign accept = |(sx_sel & sx_grant & sx_hready);

  always_comb begin
    hready_out = 1'b1;
    hresp_out  = HRESP_OKAY;
    hrdata_out = '0;
    case (state)
      ST_ADDR: if (dvalid) begin
        hready_out = sx_hready[dsel];
        hresp_out  = sx_hresp[dsel];
        hrdata_out = sx_hrdata[32*int'(dsel) +: 32];
      end
      ST_HOLD: hready_out = 1'b0;
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = HRESP_ERROR;
      end
      ST_ERR2: hresp_out = HRESP_ERROR;
      default: ;
    endcase
  end

  // ERR2 completes the default-slave response with hready high, so it takes
  // a new address phase exactly like ADDR does.
  always_comb begin
    state_nxt  = state;
    dvalid_nxt = dvalid;
    dsel_nxt   = dsel;
    capture    = 1'b0;
    case (state)
      ST_ADDR, ST_ERR2: if (hready_out) begin
        state_nxt  = ST_ADDR;
        dvalid_nxt = 1'b0;
        if (xfer_vld) begin
          if (dec_miss) begin
            state_nxt = ST_ERR1;
          end else if (accept) begin
            dvalid_nxt = 1'b1;
            dsel_nxt   = dec_idx;
          end else begin
            state_nxt = ST_HOLD;
            capture   = 1'b1;
          end
        end
      end
      ST_HOLD: if (accept) begin
        state_nxt  = ST_ADDR;
        dvalid_nxt = 1'b1;
        dsel_nxt   = dec_idx;
      end
      ST_ERR1: begin
        state_nxt  = ST_ERR2;
        dvalid_nxt = 1'b0;
      end
      default: state_nxt = ST_ADDR;
    endcase
  end

  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_ADDR;
      dvalid     <= 1'b0;
      dsel       <= '0;
      hold_addr  <= '0;
      hold_trans <= HTRANS_IDLE;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
    end else begin
      state  <= state_nxt;
      dvalid <= dvalid_nxt;
      dsel   <= dsel_nxt;
      if (capture) begin
        hold_addr  <= haddr;
        hold_trans <= htrans;
        hold_write <= hwrite;
        hold_size  <= hsize;
        hold_burst <= hburst;
      end
    end
  end

endmodule

// File: tb/tb_ml_ahb_master_port_stage.sv
// Directed table-driven bench for ml_ahb_master_port_stage plus a reset-during-HOLD sequence.
module tb_ml_ahb_master_port_stage;

  logic        hclk = 1'b0;
  logic        resetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hready_out, hresp_out;
  logic [31:0] hrdata_out;
  logic [1:0]  sx_sel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize, s_hburst;
  logic [1:0]  sx_grant, sx_hready, sx_hresp;
  logic [63:0] sx_hrdata;

  localparam logic [31:0] RD0 = 32'hAAAA_0000;
  localparam logic [31:0] RD1 = 32'hBBBB_0001;
  localparam logic [1:0]  ID = 2'b00, BS = 2'b01, NS = 2'b10, SQ = 2'b11;

  always #5 hclk = ~hclk;

  ml_ahb_master_port_stage dut (
    .hclk(hclk), .resetn(resetn), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hready_out(hready_out), .hresp_out(hresp_out),
    .hrdata_out(hrdata_out), .sx_sel(sx_sel), .s_haddr(s_haddr), .s_htrans(s_htrans),
    .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst), .sx_grant(sx_grant),
    .sx_hready(sx_hready), .sx_hresp(sx_hresp), .sx_hrdata(sx_hrdata)
  );

  typedef struct {
    logic [31:0] haddr;
    logic [1:0]  htrans, grant, shrdy, shresp;
    logic [1:0]  e_sel;
    logic        e_rdy, e_resp;
    logic [31:0] e_rdata, e_saddr;
    logic [1:0]  e_strans;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic [31:0] a, logic [1:0] t, logic [1:0] g, logic [1:0] r,
                              logic [1:0] rs, logic [1:0] esel, logic erdy, logic eresp,
                              logic [31:0] edata, logic [31:0] esa, logic [1:0] est);
    vec_t v;
    v.haddr = a; v.htrans = t; v.grant = g; v.shrdy = r; v.shresp = rs;
    v.e_sel = esel; v.e_rdy = erdy; v.e_resp = eresp; v.e_rdata = edata;
    v.e_saddr = esa; v.e_strans = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [1:0] g,
                       input logic [1:0] r, input logic [1:0] rs);
    haddr = a; htrans = t; sx_grant = g; sx_hready = r; sx_hresp = rs;
  endtask

  initial begin
    // granted access to slave 1
    vecs.push_back(mk(32'h1000_0004, NS, 2'b10, 2'b11, 2'b00, 2'b10, 1, 0, 0,   32'h1000_0004, NS));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, RD1, 32'h0,         ID));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h0,         ID));
    // held access to slave 0, 3 wait states, master moves on to 0x14
    vecs.push_back(mk(32'h10,        NS, 2'b00, 2'b11, 2'b00, 2'b01, 1, 0, 0,   32'h10,        NS));
    vecs.push_back(mk(32'h14,        SQ, 2'b00, 2'b11, 2'b00, 2'b01, 0, 0, 0,   32'h10,        NS));
    vecs.push_back(mk(32'h14,        SQ, 2'b00, 2'b11, 2'b00, 2'b01, 0, 0, 0,   32'h10,        NS));
    vecs.push_back(mk(32'h14,        SQ, 2'b01, 2'b11, 2'b00, 2'b01, 0, 0, 0,   32'h10,        NS));
    vecs.push_back(mk(32'h14,        SQ, 2'b01, 2'b11, 2'b00, 2'b01, 1, 0, RD0, 32'h14,        SQ));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, RD0, 32'h0,         ID));
    // unmapped -> default slave ERROR
    vecs.push_back(mk(32'h2000_0000, NS, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h2000_0000, NS));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 0, 1, 0,   32'h0,         ID));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 1, 0,   32'h0,         ID));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h0,         ID));
    // BUSY to mapped address
    vecs.push_back(mk(32'h1000_0000, BS, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h1000_0000, BS));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h0,         ID));
    // INCR4 burst to slave 1 with 2 slave wait states and an ERROR passthrough
    vecs.push_back(mk(32'h1000_0000, NS, 2'b10, 2'b11, 2'b00, 2'b10, 1, 0, 0,   32'h1000_0000, NS));
    vecs.push_back(mk(32'h1000_0004, SQ, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, RD1, 32'h1000_0004, SQ));
    vecs.push_back(mk(32'h1000_0004, SQ, 2'b10, 2'b01, 2'b00, 2'b10, 0, 0, RD1, 32'h1000_0004, SQ));
    vecs.push_back(mk(32'h1000_0004, SQ, 2'b10, 2'b11, 2'b00, 2'b10, 1, 0, RD1, 32'h1000_0004, SQ));
    vecs.push_back(mk(32'h1000_0008, SQ, 2'b10, 2'b11, 2'b00, 2'b10, 1, 0, RD1, 32'h1000_0008, SQ));
    vecs.push_back(mk(32'h1000_000C, SQ, 2'b10, 2'b11, 2'b10, 2'b10, 1, 1, RD1, 32'h1000_000C, SQ));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, RD1, 32'h0,         ID));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h0,         ID));
    // miss, then a new transfer presented during ERR1/ERR2 is taken in ERR2
    vecs.push_back(mk(32'h3000_0000, NS, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0,   32'h3000_0000, NS));
    vecs.push_back(mk(32'h20,        NS, 2'b01, 2'b11, 2'b00, 2'b01, 0, 1, 0,   32'h20,        NS));
    vecs.push_back(mk(32'h20,        NS, 2'b01, 2'b11, 2'b00, 2'b01, 1, 1, 0,   32'h20,        NS));
    vecs.push_back(mk(32'h0,         ID, 2'b00, 2'b11, 2'b00, 2'b00, 1, 0, RD0, 32'h0,         ID));

    resetn = 1'b0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
    sx_hrdata = {RD1, RD0};
    drive(32'h0, ID, 2'b00, 2'b11, 2'b00);
    #3;
    chk("rst hready_out", 32'(hready_out), 32'd1);
    chk("rst hresp_out",  32'(hresp_out),  32'd0);
    chk("rst hrdata_out", hrdata_out,      32'd0);
    chk("rst sx_sel",     32'(sx_sel),     32'd0);
    chk("rst s_htrans",   32'(s_htrans),   32'd0);
    @(posedge hclk); @(posedge hclk); #1 resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge hclk); #1;
      drive(vecs[i].haddr, vecs[i].htrans, vecs[i].grant, vecs[i].shrdy, vecs[i].shresp);
      #4;
      chk($sformatf("v%0d sx_sel", i),     32'(sx_sel),     32'(vecs[i].e_sel));
      chk($sformatf("v%0d hready_out", i), 32'(hready_out), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d hresp_out", i),  32'(hresp_out),  32'(vecs[i].e_resp));
      chk($sformatf("v%0d hrdata_out", i), hrdata_out,      vecs[i].e_rdata);
      chk($sformatf("v%0d s_haddr", i),    s_haddr,         vecs[i].e_saddr);
      chk($sformatf("v%0d s_htrans", i),   32'(s_htrans),   32'(vecs[i].e_strans));
    end

    // reset pulsed while a transfer is held
    @(posedge hclk); #1 drive(32'h10, NS, 2'b00, 2'b11, 2'b00);
    @(posedge hclk); #1 drive(32'h20, NS, 2'b00, 2'b11, 2'b00);
    #2;
    chk("hold hready_out", 32'(hready_out), 32'd0);
    chk("hold s_haddr",    s_haddr,         32'h10);
    resetn = 1'b0;
    #1;
    chk("arst sx_sel",     32'(sx_sel),     32'd0);
    chk("arst s_htrans",   32'(s_htrans),   32'd0);
    chk("arst hready_out", 32'(hready_out), 32'd1);
    chk("arst hresp_out",  32'(hresp_out),  32'd0);
    htrans = ID;
    @(posedge hclk); #1 resetn = 1'b1;
    @(posedge hclk); #1 drive(32'h1000_0000, NS, 2'b10, 2'b11, 2'b00);
    #4;
    chk("post sx_sel",     32'(sx_sel),     32'h2);
    chk("post s_haddr",    s_haddr,         32'h1000_0000);
    chk("post hready_out", 32'(hready_out), 32'd1);
    @(posedge hclk); #1 drive(32'h0, ID, 2'b00, 2'b11, 2'b00);
    #4;
    chk("post hrdata_out", hrdata_out,      RD1);
    chk("post hready2",    32'(hready_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
